spi_cfg_bridge: RTL and testbench

Serial-to-parallel host bridge sitting directly upstream of the 8 x 16-bit configuration register file. Receives SPI mode-0 frames from an external host and converts each frame into a single-cycle register-file write strobe or a register read. Read data is returned serially on miso. Runs entirely in the clk domain, oversampling sclk and cs_n.

---
 rtl/spi_cfg_bridge.sv | 195 +++++++++++++++++++
 tb/tb_spi_cfg_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_bridge.sv
// SPI mode-0 slave that turns 20-bit host frames into register-file writes and reads.
// Frame: RW, address (MSB first), data (MSB first). sclk, cs_n and mosi are oversampled
// in the clk domain; all outputs are registered.
module spi_cfg_bridge #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              cfg_write,
    output logic [ADDR_W-1:0] cfg_address,
    output logic [DATA_W-1:0] cfg_data_in,
    input  logic [DATA_W-1:0] cfg_data_out,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CmdBits   = 1 + ADDR_W;
    localparam int unsigned FrameBits = CmdBits + DATA_W;
    localparam int unsigned CntW      = $clog2(FrameBits + 1);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StWaitCs} state_e;

    // Synchroniser chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;

    // Frame state
    state_e                 state_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic                   rw_q;
    logic [ADDR_W-1:0]      addr_shift_q;
    logic [DATA_W-1:0]      rx_shift_q, tx_shift_q;
    logic [1:0]             rd_cap_q;
    logic                   wr_pend_q;

    // Registered outputs
    logic                   miso_q, cfg_write_q, busy_q, frame_err_q;
    logic [ADDR_W-1:0]      cfg_address_q;
    logic [DATA_W-1:0]      cfg_data_in_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] rx_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // sclk edges only count while the frame is selected
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign addr_next = {addr_shift_q[ADDR_W-2:0], mosi_s};
    assign rx_next   = {rx_shift_q[DATA_W-2:0], mosi_s};

    // Synchronise the SPI pins; arm frame detection only once cs_n has been seen high
    // from the real pin, so a frame already running at reset release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            if (fill_q[SYNC_STAGES-1] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            rw_q          <= 1'b0;
            addr_shift_q  <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rd_cap_q      <= '0;
            wr_pend_q     <= 1'b0;
            miso_q        <= 1'b0;
            cfg_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            cfg_address_q <= '0;
            cfg_data_in_q <= '0;
        end else begin
            cfg_write_q <= wr_pend_q;
            wr_pend_q   <= 1'b0;
            frame_err_q <= 1'b0;
            // Read data is valid one clk after the address update; grab it the clk after
            rd_cap_q    <= {rd_cap_q[0], 1'b0};
            if (wr_pend_q) begin
                cfg_data_in_q <= rx_shift_q;
            end
            if (rd_cap_q[1]) begin
                tx_shift_q <= cfg_data_out;
            end

            case (state_q)
                StIdle: begin
                    miso_q <= 1'b0;
                    if (armed_q && cs_fall) begin
                        state_q   <= StCmd;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StCmd: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        rd_cap_q    <= '0;
                    end else if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '0) begin
                            rw_q <= mosi_s;
                        end else begin
                            addr_shift_q <= addr_next;
                        end
                        if (bit_cnt_q == CntW'(CmdBits - 1)) begin
                            cfg_address_q <= addr_next;
                            state_q       <= StData;
                            if (!rw_q) begin
                                rd_cap_q <= 2'b01;
                            end
                        end
                    end
                end
                StData: begin
                    if (cs_rise) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        rd_cap_q    <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_q <= rx_next;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == CntW'(FrameBits - 1)) begin
                                wr_pend_q <= rw_q;
                                state_q   <= StWaitCs;
                            end
                        end
                        if (sclk_fall && !rw_q) begin
                            miso_q     <= tx_shift_q[DATA_W-1];
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                StWaitCs: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign miso        = miso_q;
    assign cfg_write   = cfg_write_q;
    assign cfg_address = cfg_address_q;
    assign cfg_data_in = cfg_data_in_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_cfg_bridge.sv
// Bench for spi_cfg_bridge: SPI host driver, attached 8x16 register file and a
// register-array reference model; directed frames followed by random ones.
module tb_spi_cfg_bridge;

    localparam int SYNC = 2;
    localparam logic [15:0] RST_VALS [8] = '{16'hFFFF, 16'h0F0F, 16'h5555, 16'h0000,
                                             16'h00A0, 16'hABCD, 16'h3C3C, 16'h0001};

    logic        clk = 1'b0;
    logic        reset, sclk, cs_n, mosi;
    logic        miso, cfg_write, busy, frame_err;
    logic [2:0]  cfg_address;
    logic [15:0] cfg_data_in, cfg_data_out;

    spi_cfg_bridge #(.ADDR_W(3), .DATA_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .cfg_write    (cfg_write),
        .cfg_address  (cfg_address),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous write, one-clk registered read
    logic [15:0] rf [8];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= RST_VALS[i];
            cfg_data_out <= '0;
        end else begin
            if (cfg_write) rf[cfg_address] <= cfg_data_in;
            cfg_data_out <= rf[cfg_address];
        end
    end

    // Pulse monitor: counts high cycles so a stretched pulse is noticed
    int          wr_cnt = 0, err_cnt = 0, wr_cyc = 0;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    always @(negedge clk) begin
        if (cfg_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= cfg_address;
            wr_data <= cfg_data_in;
            wr_cyc  <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    logic [15:0] exp_regs [8];
    int n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_miso"}, miso, 0);
        check_eq({pfx, "_cfg_write"}, cfg_write, 0);
        check_eq({pfx, "_cfg_address"}, cfg_address, 0);
        check_eq({pfx, "_cfg_data_in"}, cfg_data_in, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_frame_err"}, frame_err, 0);
    endtask

    // Mode-0 host: mosi changes with sclk low, miso sampled at each rise
    task automatic spi_xfer(input int nbits, input logic [31:0] f, input int reset_at,
                            input int half, output logic [15:0] rd, output int r20);
        rd  = '0;
        r20 = 0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (half) @(negedge clk);
        check_eq("busy_frame", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_reset_outputs("midrst");
            end
            mosi = f[nbits-1-i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            if (i == 19) r20 = cyc;
            if (i >= 4 && i < 20) rd = {rd[14:0], miso};
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (half) @(negedge clk);
        cs_n = 1'b1;
        repeat (half + 4) @(negedge clk);
    endtask

    task automatic run_frame(input logic rw, input logic [2:0] addr, input logic [15:0] data,
                             input int nbits, input int reset_at, input int half);
        logic [31:0] f;
        logic [15:0] rd;
        int          r20, wr0, er0;
        bit          complete;
        f = {12'd0, rw, addr, data};
        if (nbits >= 20) f = (f << (nbits - 20)) | ($urandom() & ((32'd1 << (nbits - 20)) - 1));
        else f = f >> (20 - nbits);
        wr0 = wr_cnt;
        er0 = err_cnt;
        spi_xfer(nbits, f, reset_at, half, rd, r20);
        complete = (nbits >= 20) && (reset_at < 0);
        if (reset_at >= 0) for (int i = 0; i < 8; i++) exp_regs[i] = RST_VALS[i];
        check_eq("wr_count", wr_cnt - wr0, (complete && rw) ? 1 : 0);
        check_eq("err_count", err_cnt - er0, (nbits < 20 && reset_at < 0) ? 1 : 0);
        check_eq("busy_after", busy, 0);
        if (complete && rw) begin
            check_eq("wr_addr", wr_addr, addr);
            check_eq("wr_data", wr_data, data);
            check_eq("wr_latency", wr_cyc - r20, SYNC + 2);
            check_eq("miso_on_write", rd, 0);
            exp_regs[addr] = data;
        end
        if (complete && !rw) check_eq("rd_data", rd, exp_regs[addr]);
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        for (int i = 0; i < 8; i++) exp_regs[i] = RST_VALS[i];
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_frame(1'b0, 3'd0, 16'h0000, 20, -1, 5);
        run_frame(1'b0, 3'd7, 16'h0000, 20, -1, 5);
        run_frame(1'b1, 3'd4, 16'h1234, 20, -1, 5);
        run_frame(1'b1, 3'd3, 16'hFFFF, 20, -1, 5);
        run_frame(1'b0, 3'd3, 16'h0000, 20, -1, 5);
        run_frame(1'b0, 3'd5, 16'h0000, 20, -1, 5);
        run_frame(1'b0, 3'd4, 16'h0000, 20, -1, 5);
        // Abort after 10 bits, then a full frame
        run_frame(1'b1, 3'd1, 16'hBEEF, 10, -1, 5);
        run_frame(1'b1, 3'd1, 16'h0F00, 20, -1, 5);
        run_frame(1'b0, 3'd1, 16'h0000, 20, -1, 4);
        // Over-long frame: trailing bits ignored
        run_frame(1'b1, 3'd2, 16'h00A5, 24, -1, 5);
        run_frame(1'b0, 3'd2, 16'h0000, 20, -1, 6);
        // Reset during bit 12, then normal traffic
        run_frame(1'b1, 3'd6, 16'h7777, 20, 12, 5);
        run_frame(1'b0, 3'd6, 16'h0000, 20, -1, 5);
        run_frame(1'b1, 3'd6, 16'h9A9A, 20, -1, 5);
        run_frame(1'b0, 3'd6, 16'h0000, 20, -1, 5);

        for (int k = 0; k < 40; k++) begin
            int mode, nb;
            mode = $urandom_range(0, 9);
            if (mode < 7) nb = 20;
            else if (mode == 7) nb = 20 + $urandom_range(1, 4);
            else nb = $urandom_range(1, 19);
            run_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
                      nb, -1, $urandom_range(4, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
